// File: rtl/sim_mem_trace_replayer.sv
// Trace replayer: buffers timestamped memory requests per lane and releases each
// one on its lane once the local cycle counter reaches the record's timestamp.
module sim_mem_trace_replayer #(
  parameter int unsigned NUM_LANES     = 4,
  parameter int unsigned DEPTH         = 4,
  parameter int unsigned DATA_WIDTH    = 64,
  parameter int unsigned SOURCE_WIDTH  = 8,
  parameter int unsigned LOGSIZE_WIDTH = 4,
  localparam int unsigned LaneW        = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [DATA_WIDTH-1:0]                in_cycle,
  input  logic [LaneW-1:0]                     in_lane,
  input  logic [SOURCE_WIDTH-1:0]              in_source,
  input  logic [DATA_WIDTH-1:0]                in_address,
  input  logic                                 in_is_store,
  input  logic [LOGSIZE_WIDTH-1:0]             in_size,
  input  logic [DATA_WIDTH-1:0]                in_data,
  input  logic                                 in_last,
  output logic [NUM_LANES-1:0]                 out_valid,
  input  logic [NUM_LANES-1:0]                 out_ready,
  output logic [NUM_LANES*SOURCE_WIDTH-1:0]    out_source,
  output logic [NUM_LANES*DATA_WIDTH-1:0]      out_address,
  output logic [NUM_LANES-1:0]                 out_is_store,
  output logic [NUM_LANES*LOGSIZE_WIDTH-1:0]   out_size,
  output logic [NUM_LANES*DATA_WIDTH-1:0]      out_data,
  output logic [31:0]                          late_count,
  output logic                                 done
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0]    r_counter;
  logic [DATA_WIDTH-1:0]    r_cyc_mem   [NUM_LANES][DEPTH];
  logic [SOURCE_WIDTH-1:0]  r_src_mem   [NUM_LANES][DEPTH];
  logic [DATA_WIDTH-1:0]    r_addr_mem  [NUM_LANES][DEPTH];
  logic                     r_store_mem [NUM_LANES][DEPTH];
  logic [LOGSIZE_WIDTH-1:0] r_size_mem  [NUM_LANES][DEPTH];
  logic [DATA_WIDTH-1:0]    r_data_mem  [NUM_LANES][DEPTH];
  logic [PtrW-1:0]          r_wptr      [NUM_LANES];
  logic [PtrW-1:0]          r_rptr      [NUM_LANES];
  logic [PtrW:0]            r_cnt       [NUM_LANES];
  logic                     r_last_seen;
  logic                     r_done;
  logic [31:0]              r_late;

  logic [LaneW-1:0]         w_lane;
  logic                     w_push;
  logic [NUM_LANES-1:0]     w_push_vec;
  logic [NUM_LANES-1:0]     w_empty;
  logic [NUM_LANES-1:0]     w_full;
  logic [NUM_LANES-1:0]     w_live;
  logic [NUM_LANES-1:0]     w_fire;
  logic [DATA_WIDTH-1:0]    w_head_cyc  [NUM_LANES];
  logic [31:0]              w_late_add;
  logic [32:0]              w_late_sum;

  // Out-of-range lane ids fold onto the last lane.
  assign w_lane     = (32'(in_lane) >= NUM_LANES) ? LaneW'(NUM_LANES - 1) : in_lane;
  assign in_ready   = !reset && !w_full[w_lane];
  assign w_push     = in_valid && in_ready;
  assign w_late_sum = {1'b0, r_late} + {1'b0, w_late_add};
  assign late_count = r_late;
  assign done       = r_done;

  always_comb begin
    w_empty      = '0;
    w_full       = '0;
    w_live       = '0;
    w_fire       = '0;
    w_push_vec   = '0;
    w_late_add   = '0;
    out_valid    = '0;
    out_source   = '0;
    out_address  = '0;
    out_is_store = '0;
    out_size     = '0;
    out_data     = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      w_empty[l]    = (r_cnt[l] == '0);
      w_full[l]     = (r_cnt[l] == (PtrW + 1)'(DEPTH));
      w_push_vec[l] = w_push && (w_lane == LaneW'(l));
      w_head_cyc[l] = r_cyc_mem[l][r_rptr[l]];
      w_live[l]     = !reset && !w_empty[l];
      out_valid[l]  = w_live[l] && (w_head_cyc[l] <= r_counter);
      if (w_live[l]) begin
        out_source[l*SOURCE_WIDTH +: SOURCE_WIDTH]    = r_src_mem[l][r_rptr[l]];
        out_address[l*DATA_WIDTH +: DATA_WIDTH]       = r_addr_mem[l][r_rptr[l]];
        out_is_store[l]                               = r_store_mem[l][r_rptr[l]];
        out_size[l*LOGSIZE_WIDTH +: LOGSIZE_WIDTH]    = r_size_mem[l][r_rptr[l]];
        out_data[l*DATA_WIDTH +: DATA_WIDTH]          = r_data_mem[l][r_rptr[l]];
      end
      w_fire[l] = out_valid[l] && out_ready[l];
      if (w_fire[l] && (w_head_cyc[l] < r_counter)) begin
        w_late_add = w_late_add + 32'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    for (int l = 0; l < NUM_LANES; l++) begin
      if (w_push_vec[l]) begin
        r_cyc_mem[l][r_wptr[l]]   <= in_cycle;
        r_src_mem[l][r_wptr[l]]   <= in_source;
        r_addr_mem[l][r_wptr[l]]  <= in_address;
        r_store_mem[l][r_wptr[l]] <= in_is_store;
        r_size_mem[l][r_wptr[l]]  <= in_size;
        r_data_mem[l][r_wptr[l]]  <= in_data;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_counter   <= '0;
      r_last_seen <= 1'b0;
      r_done      <= 1'b0;
      r_late      <= '0;
      for (int l = 0; l < NUM_LANES; l++) begin
        r_wptr[l] <= '0;
        r_rptr[l] <= '0;
        r_cnt[l]  <= '0;
      end
    end else begin
      r_counter <= r_counter + DATA_WIDTH'(1);
      if (w_push && in_last) r_last_seen <= 1'b1;
      if (r_last_seen && (&w_empty) && !w_push) r_done <= 1'b1;
      r_late <= w_late_sum[32] ? 32'hFFFF_FFFF : w_late_sum[31:0];
      for (int l = 0; l < NUM_LANES; l++) begin
        if (w_push_vec[l]) r_wptr[l] <= r_wptr[l] + PtrW'(1);
        if (w_fire[l])     r_rptr[l] <= r_rptr[l] + PtrW'(1);
        case ({w_push_vec[l], w_fire[l]})
          2'b10:   r_cnt[l] <= r_cnt[l] + (PtrW + 1)'(1);
          2'b01:   r_cnt[l] <= r_cnt[l] - (PtrW + 1)'(1);
          default: r_cnt[l] <= r_cnt[l];
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sim_mem_trace_replayer.sv
// Directed bench for sim_mem_trace_replayer: timed release, lateness, backpressure,
// multi-lane release, reset flush and done.
module tb_sim_mem_trace_replayer;

  logic         clock;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [63:0]  in_cycle;
  logic [1:0]   in_lane;
  logic [7:0]   in_source;
  logic [63:0]  in_address;
  logic         in_is_store;
  logic [3:0]   in_size;
  logic [63:0]  in_data;
  logic         in_last;
  logic [3:0]   out_valid;
  logic [3:0]   out_ready;
  logic [31:0]  out_source;
  logic [255:0] out_address;
  logic [3:0]   out_is_store;
  logic [15:0]  out_size;
  logic [255:0] out_data;
  logic [31:0]  late_count;
  logic         done;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  sim_mem_trace_replayer dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_cycle    (in_cycle),
    .in_lane     (in_lane),
    .in_source   (in_source),
    .in_address  (in_address),
    .in_is_store (in_is_store),
    .in_size     (in_size),
    .in_data     (in_data),
    .in_last     (in_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_source  (out_source),
    .out_address (out_address),
    .out_is_store(out_is_store),
    .out_size    (out_size),
    .out_data    (out_data),
    .late_count  (late_count),
    .done        (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic set_rec(input int lane, input logic [63:0] ts, input logic [63:0] addr,
                         input logic last);
    in_valid    = 1'b1;
    in_lane     = 2'(lane);
    in_cycle    = ts;
    in_address  = addr;
    in_source   = 8'(lane + 1);
    in_is_store = 1'b1;
    in_size     = 4'd3;
    in_data     = ~addr;
    in_last     = last;
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_last  = 1'b0;
    #1;
  endtask

  function automatic logic [63:0] addr_of(input int lane);
    return out_address[lane*64 +: 64];
  endfunction

  initial begin
    reset     = 1'b1;
    out_ready = 4'b1111;
    in_valid  = 1'b0;
    in_cycle  = '0;
    in_lane   = '0;
    in_source = '0;
    in_address = '0;
    in_is_store = 1'b0;
    in_size   = '0;
    in_data   = '0;
    in_last   = 1'b0;
    tick();
    tick();
    chk("reset_in_ready", 64'(in_ready), 64'd0);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_late", 64'(late_count), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_addr2", addr_of(2), 64'd0);

    reset = 1'b0;
    cyc   = 0;
    #1;

    // Single timed record: cycle 5 on lane 2, accepted at counter 0.
    set_rec(2, 64'd5, 64'h1000, 1'b0);
    chk("t1_in_ready", 64'(in_ready), 64'd1);
    tick();
    idle();
    for (int c = 1; c <= 6; c++) begin
      chk("t1_out_valid", 64'(out_valid), (c == 5) ? 64'h4 : 64'h0);
      if (c == 5) chk("t1_addr", addr_of(2), 64'h1000);
      tick();
    end
    chk("t1_late", 64'(late_count), 64'd0);

    // Late record: cycle 3 accepted at counter 10.
    while (cyc < 10) tick();
    set_rec(0, 64'd3, 64'h2000, 1'b0);
    chk("t2_in_ready", 64'(in_ready), 64'd1);
    tick();
    idle();
    chk("t2_out_valid", 64'(out_valid), 64'h1);
    chk("t2_addr", addr_of(0), 64'h2000);
    tick();
    chk("t2_out_valid_after", 64'(out_valid), 64'h0);
    chk("t2_late", 64'(late_count), 64'd1);

    // All four lanes due at counter 20.
    for (int l = 0; l < 4; l++) begin
      set_rec(l, 64'd20, 64'h5000 + 64'(l), 1'b0);
      chk("t4_in_ready", 64'(in_ready), 64'd1);
      tick();
    end
    idle();
    while (cyc < 20) begin
      chk("t4_early_valid", 64'(out_valid), 64'h0);
      tick();
    end
    chk("t4_all_valid", 64'(out_valid), 64'hF);
    chk("t4_addr3", addr_of(3), 64'h5003);
    tick();
    chk("t4_after_valid", 64'(out_valid), 64'h0);
    chk("t4_late", 64'(late_count), 64'd1);

    // Lane 0 backpressure: fill lane 0, confirm lane 1 still enters, then drain in order.
    out_ready = 4'b1110;
    for (int i = 0; i < 4; i++) begin
      set_rec(0, 64'd0, 64'h3000 + 64'(i), 1'b0);
      chk("t3_fill_ready", 64'(in_ready), 64'd1);
      tick();
    end
    set_rec(0, 64'd0, 64'h3004, 1'b0);
    chk("t3_full_ready", 64'(in_ready), 64'd0);
    chk("t3_stall_valid", 64'(out_valid), 64'h1);
    chk("t3_stall_addr", addr_of(0), 64'h3000);
    set_rec(1, 64'd0, 64'h4000, 1'b0);
    chk("t3_lane1_ready", 64'(in_ready), 64'd1);
    tick();
    idle();
    chk("t3_both_valid", 64'(out_valid), 64'h3);
    chk("t3_hold_addr", addr_of(0), 64'h3000);
    chk("t3_lane1_addr", addr_of(1), 64'h4000);
    tick();
    out_ready = 4'b1111;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("t3_drain_valid", 64'(out_valid[0]), 64'd1);
      chk("t3_drain_addr", addr_of(0), 64'h3000 + 64'(i));
      tick();
    end
    chk("t3_empty_valid", 64'(out_valid), 64'h0);
    chk("t3_late", 64'(late_count), 64'd6);

    // Reset with three records queued and stalled.
    out_ready = 4'b0000;
    for (int l = 0; l < 3; l++) begin
      set_rec(l, 64'd0, 64'h7000 + 64'(l), 1'b0);
      tick();
    end
    idle();
    chk("t6_pre_valid", 64'(out_valid), 64'h7);
    reset = 1'b1;
    set_rec(3, 64'd0, 64'h7003, 1'b0);
    chk("t6_rst_valid", 64'(out_valid), 64'h0);
    chk("t6_rst_ready", 64'(in_ready), 64'd0);
    tick();
    chk("t6_rst_valid2", 64'(out_valid), 64'h0);
    chk("t6_rst_ready2", 64'(in_ready), 64'd0);
    chk("t6_rst_addr0", addr_of(0), 64'd0);
    tick();
    reset     = 1'b0;
    out_ready = 4'b1111;
    cyc       = 0;
    idle();
    chk("t6_late", 64'(late_count), 64'd0);
    chk("t6_done", 64'(done), 64'd0);
    chk("t6_in_ready", 64'(in_ready), 64'd1);
    for (int c = 0; c < 4; c++) begin
      chk("t6_no_stale", 64'(out_valid), 64'h0);
      tick();
    end

    // Final record with in_last at cycle 8; counter restarted from 0.
    set_rec(3, 64'd8, 64'h6000, 1'b1);
    chk("t5_in_ready", 64'(in_ready), 64'd1);
    chk("t5_done_pre", 64'(done), 64'd0);
    tick();
    idle();
    for (int c = 5; c <= 11; c++) begin
      chk("t5_out_valid", 64'(out_valid), (c == 8) ? 64'h8 : 64'h0);
      if (c == 8) chk("t5_addr", addr_of(3), 64'h6000);
      chk("t5_done", 64'(done), (c >= 10) ? 64'd1 : 64'd0);
      tick();
    end
    chk("t5_done_sticky", 64'(done), 64'd1);
    chk("t5_late", 64'(late_count), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sim_mem_trace_replayer.md
# sim_mem_trace_replayer

Trace-driven request generator for the simulated memory path; it is the producing end of the per-lane trace interface that the memory trace logger consumes. It accepts timestamped trace records from an upstream reader over a valid/ready stream and buffers them per lane. It releases each record on its lane's request port once the local cycle counter reaches the record's timestamp. The block sits between the trace-file reader and the core-side memory request ports in trace-replay simulations.

## Interface
- NUM_LANES, 4: number of request lanes; lane 0 is the LSB slice of every packed bus.
- DEPTH, 4: per-lane FIFO entries; power of two, at least 2.
- DATA_WIDTH, 64: width of cycle, address and data fields.
- SOURCE_WIDTH, 8: source-id width.
- LOGSIZE_WIDTH, 4: log2(bytes) size-field width.
- clock  in  1  single clock.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  record available.
- in_ready  out  1  record accepted this cycle when high together with in_valid.
- in_cycle  in  DATA_WIDTH  release timestamp.
- in_lane  in  $clog2(NUM_LANES)  target lane.
- in_source  in  SOURCE_WIDTH  source id.
- in_address  in  DATA_WIDTH  byte address.
- in_is_store  in  1  store flag.
- in_size  in  LOGSIZE_WIDTH  log2 size.
- in_data  in  DATA_WIDTH  store data.
- in_last  in  1  marks the final record of the trace.
- out_valid  out  NUM_LANES  per-lane request valid.
- out_ready  in  NUM_LANES  per-lane request ready.
- out_source / out_address / out_is_store / out_size / out_data  out  packed NUM_LANES × field width  per-lane request fields.
- late_count  out  32  saturating count of requests issued after their timestamp.
- done  out  1  trace fully drained.

## Operation
- Cycle counter:
  - DATA_WIDTH bits, held at 0 while reset is high.
  - Reads 0 in the first cycle after reset deasserts and increments by 1 every cycle thereafter, so it aligns with the logger's counter.
  - Wraps modulo 2^DATA_WIDTH with no special handling.
- Ingress:
  - in_ready = !reset && !full[in_lane]. A pop in the same cycle does not free a slot for a push.
  - Record lane values at or above NUM_LANES are treated as lane NUM_LANES-1.
  - An accepted record is written to its lane's FIFO tail at the clock edge.
  - If in_last is set on the accepted record, the sticky flag last_seen is set.
- Release, per lane independently:
  - out_valid[l] = head present && head.cycle <= counter (unsigned compare).
  - Output fields always show the lane's head entry and are zero when the FIFO is empty.
  - Fire = out_valid[l] && out_ready[l]; the head pops at the edge.
  - Records leave each lane in FIFO order. An earlier-timestamped record queued behind a later one is not reordered.
- late_count:
  - Each cycle it adds the number of lanes that fire with head.cycle < counter.
  - It saturates at 2^32-1.
- done:
  - Registered; set on the edge where last_seen is high and every FIFO is empty with no push in that cycle.
  - Sticky until reset.
- Reset mid-operation: all FIFOs are emptied and the counter, last_seen, done and late_count are cleared.

## Timing
- Reset values:
  - in_ready = 0, out_valid = 0, all out_* fields = 0.
  - late_count = 0, done = 0.
- Minimum latency: a record accepted in cycle k can first assert out_valid in cycle k+1, or in the cycle where counter == in_cycle if that is later.
- A record with in_cycle = T accepted early asserts out_valid exactly in the cycle where counter == T.
- Back-to-back: after a pop, the next entry is the head in the following cycle. One request per lane per cycle is sustained when both are due.
- While out_ready is low, out_valid and the head fields stay stable and the counter keeps running.
- Full FIFO: in_ready stays low for that lane only; records for other lanes still enter, so there is no head-of-line blocking across lanes beyond the single input stream.
- No combinational path from out_ready to in_ready.

## Test plan
- Single record with cycle=5, lane=2, address=0x1000, accepted at counter 0, out_ready=1 -> out_valid[2] is high only in the counter==5 cycle, carrying address 0x1000; late_count=0.
- Record with cycle=3 accepted at counter 10 -> out_valid asserts at counter 11, fires, and late_count becomes 1.
- Lane 0 with out_ready=0 and DEPTH+1 records offered for lane 0 -> in_ready drops after DEPTH accepts. Records for lane 1 are still accepted. After out_ready rises, the DEPTH lane-0 records drain in order on consecutive cycles.
- All NUM_LANES lanes due on the same cycle with in_cycle=20 and out_ready all 1 -> all four fire at counter 20; late_count is unchanged.
- Final record with in_last and cycle 8 -> done rises one cycle after that record pops and stays high.
- Reset asserted with three records queued -> out_valid=0 and in_ready=0 during reset. After reset the counter restarts at 0, late_count=0, done=0, and no stale record appears.
